// File: rtl/timed_shift_reg.sv
// timed_shift_reg: prescaler-timed shift/rotate register with parallel load.
//   clk, rst (async, active-low)   clock and reset
//   en                             run enable for prescaler and shifting
//   mode                           00 shl, 01 shr, 10 rol, 11 ror
//   ser_in                         serial data inserted by shift modes
//   load, load_data                synchronous parallel load (wins over tick)
//   q, ser_out, tick               contents, leaving bit, shift strobe
//   Optional macro TSR_SHIFT_CNT_EN adds shift_cnt and done outputs.
module timed_shift_reg #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`ifdef TSR_SHIFT_CNT_EN
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       done,
`endif
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, shifted;
  logic             tick_q, tick_d, at_end, t;
  always_comb begin
    at_end  = cnt_q == CNT_W'(TICK_DIV - 1);
    t       = en & at_end & ~load;
    shifted = mode == 2'b00 ? {q_q[WIDTH-2:0], ser_in} :
              mode == 2'b01 ? {ser_in, q_q[WIDTH-1:1]} :
              mode == 2'b10 ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} :
                              {q_q[0], q_q[WIDTH-1:1]};
    cnt_d   = load ? '0 : !en ? cnt_q : at_end ? '0 : cnt_q + 1'b1;
    q_d     = load ? load_data : t ? shifted : q_q;
    tick_d  = t;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q  <= '0;
      q_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      tick_q <= tick_d;
    end
  assign q       = q_q;
  assign tick    = tick_q;
  assign ser_out = mode[0] ? q_q[0] : q_q[WIDTH-1];
`ifdef TSR_SHIFT_CNT_EN
  localparam int SCW = $clog2(WIDTH + 1);
  logic [SCW-1:0] sc_q, sc_d;
  logic           done_q, done_d;
  // Saturating count of shifts since load; done fires once when it reaches WIDTH.
  always_comb begin
    sc_d   = load ? '0 : (t && sc_q != SCW'(WIDTH)) ? sc_q + 1'b1 : sc_q;
    done_d = t && sc_q == SCW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sc_q   <= '0;
      done_q <= 1'b0;
    end else begin
      sc_q   <= sc_d;
      done_q <= done_d;
    end
  assign shift_cnt = sc_q;
  assign done      = done_q;
`endif
endmodule

// File: doc/timed_shift_reg.md
Name: timed_shift_reg

Overview:
- Parametrised, prescaler-timed shift register. Successor to the fixed 4-bit, 1 Hz serial-in shifter.
- Adds configurable width and tick period, a clock-enable, four shift/rotate modes, synchronous parallel load, serial output and a tick strobe.
- Used for LED chasers, slow serial patterns and test-pattern generators driven from the 50 MHz board clock.

Parameters:
- WIDTH, 8: register width in bits. Must be ≥ 2.
- TICK_DIV, 50000000: clk cycles per shift tick. Must be ≥ 1.
- CNT_W, 26: prescaler counter width. Must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  run enable; prescaler and shifting advance only when high
- mode  input  2  00 shift left, 01 shift right, 10 rotate left, 11 rotate right
- ser_in  input  1  serial data, inserted by the shift modes
- load  input  1  synchronous parallel-load strobe
- load_data  input  WIDTH  parallel load value
- q  output  WIDTH  register contents
- ser_out  output  1  bit leaving the register
- tick  output  1  one-cycle pulse, asserted on the cycle a shift occurs

Behaviour:
- Reset (rst low, asynchronous): cnt=0, q=0, tick=0. Takes effect immediately, including mid-period or mid-load; all state restarts from zero.
- Prescaler cnt:
  - en=1 and cnt==TICK_DIV-1: cnt←0.
  - en=1 otherwise: cnt←cnt+1.
  - en=0: cnt holds.
  - TICK_DIV=1: a tick fires on every enabled cycle.
- Tick condition T = en & (cnt==TICK_DIV-1) & ~load. tick is registered: tick←T, so tick is high in the cycle after the edge at which q shifts and is aligned with the new q.
- Priority at each rising edge:
  1. load=1: q←load_data, cnt←0, tick←0. Works regardless of en; any pending tick is discarded.
  2. T=1: q updates per mode:
     - 00: q←{q[WIDTH-2:0], ser_in}
     - 01: q←{ser_in, q[WIDTH-1:1]}
     - 10: q←{q[WIDTH-2:0], q[WIDTH-1]}
     - 11: q←{q[0], q[WIDTH-1:1]}
  3. Otherwise q holds.
- mode and ser_in are sampled only at tick edges. A mode change between ticks takes effect at the next tick; no glitching of q.
- ser_out is combinational from current q and mode: q[WIDTH-1] for modes 00/10, q[0] for modes 01/11.
- en deasserted mid-period: cnt freezes and resumes from the same value, so the remaining period is preserved.
- Simultaneous load and tick condition: load wins; no shift, cnt←0.

Optional Feature:
- Macro: TSR_SHIFT_CNT_EN.
- Defined, adds:
  - Output shift_cnt [$clog2(WIDTH+1)-1:0]: reset 0; cleared on load; increments on each shift; saturates at WIDTH.
  - Output done: registered one-cycle pulse in the cycle shift_cnt reaches WIDTH, i.e. a full word has been clocked through. No further done pulses until the next load.
- Not defined: neither port exists; remaining behaviour identical.

Test Plan (WIDTH=4, TICK_DIV=4 unless stated):
- Reset mid-operation: rst low with q=4'b1010, cnt=2 → q=0, tick=0 immediately; after release the first tick arrives after exactly 4 enabled cycles.
- Shift left, mode=00, en=1, ser_in=1 from q=0 → q = 0001, 0011, 0111, 1111 on successive ticks, ticks 4 clk apart; ser_out=1 after the 4th tick.
- Rotate right, mode=11: load 4'b1000, then 4 ticks → q = 0100, 0010, 0001, 1000; ser_out tracks q[0].
- Load/tick collision: assert load with load_data=4'b0110 on the cycle cnt==3 → q=0110, no shift, tick stays 0, next tick 4 cycles later.
- en gating: drop en at cnt=1 for 10 cycles → q and cnt frozen, no tick; after en returns the tick arrives after 3 more cycles.
- TSR_SHIFT_CNT_EN: load, mode=01, 6 ticks → shift_cnt = 1, 2, 3, 4, 4, 4; exactly one done pulse, at the 4th tick.
